// File: rtl/psum_requant_acc_if.sv
// Handshake bundle for psum_requant_acc: psum input channel and
// activation output channel, each with valid/ready.
interface psum_requant_acc_if #(
    parameter int PSUM_DATA_SIZE = 12,
    parameter int ACT_WIDTH      = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [PSUM_DATA_SIZE-1:0] in_psum;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACT_WIDTH-1:0]      out_act;
    logic                      out_sat;

    modport master (
        output in_valid,
        input  in_ready,
        output in_psum,
        input  out_valid,
        output out_ready,
        input  out_act,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_psum,
        output out_valid,
        input  out_ready,
        output out_act,
        output out_sat
    );
endinterface

// File: rtl/psum_requant_acc.sv
// Saturating psum group accumulator with requantization to activations.
// Optional PSUM_REQUANT_RELU_EN forces negative activations to zero.
module psum_requant_acc #(
    parameter int NUM_TERMS      = 4,
    parameter int ACT_WIDTH      = 8,
    parameter int ACT_FRAC       = 4,
    parameter int PSUM_DATA_SIZE = 12
) (
    input logic              clk,
    input logic              rst,
    psum_requant_acc_if.slave bus
);

    localparam int PW        = PSUM_DATA_SIZE;
    localparam int PSUM_FRAC = 5;
    localparam int CW        = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int SHIFT     = PSUM_FRAC - ACT_FRAC;
    localparam int RND       = (2 ** SHIFT) / 2;
    localparam int ACT_MAX   = (2 ** (ACT_WIDTH - 1)) - 1;
    localparam int ACT_MIN   = -(2 ** (ACT_WIDTH - 1));
    localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_OUTPUT
    } state_e;

    state_e                state_q, state_d;
    logic signed [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sat_flag_q, sat_flag_d;
    logic [ACT_WIDTH-1:0]  act_q, act_d;
    logic                  osat_q, osat_d;

    logic                  in_ready;
    logic                  out_valid;
    logic                  in_hs;
    logic                  out_hs;
    logic                  first;
    logic                  last;

    logic signed [PW:0]    sum;
    logic                  add_ovf;
    logic signed [PW-1:0]  add_val;
    logic signed [PW-1:0]  new_acc;
    logic                  new_ovf;

    logic signed [31:0]    acc_ext;
    logic signed [31:0]    rq;
    logic signed [31:0]    rq_c;
    logic                  clamp;
    logic [ACT_WIDTH-1:0]  act_new;

    assign in_hs  = bus.in_valid && in_ready;
    assign out_hs = out_valid && bus.out_ready;
    assign first  = (cnt_q == '0);
    assign last   = (cnt_q == LAST);

    // Saturating add; first term of a group replaces the accumulator.
    always_comb begin
        sum     = {acc_q[PW-1], acc_q} + {bus.in_psum[PW-1], bus.in_psum};
        add_ovf = sum[PW] ^ sum[PW-1];
        add_val = sum[PW-1:0];
        if (add_ovf) begin
            if (sum[PW]) begin
                add_val = {1'b1, {(PW-1){1'b0}}};
            end else begin
                add_val = {1'b0, {(PW-1){1'b1}}};
            end
        end
        new_acc = first ? $signed(bus.in_psum) : add_val;
        new_ovf = !first && add_ovf;
    end

    // Round-half-up shift to the activation format, then clamp.
    always_comb begin
        acc_ext = 32'(new_acc);
        rq      = (acc_ext + RND) >>> SHIFT;
        rq_c    = rq;
        clamp   = 1'b0;
        if (rq > ACT_MAX) begin
            rq_c  = ACT_MAX;
            clamp = 1'b1;
        end else if (rq < ACT_MIN) begin
            rq_c  = ACT_MIN;
            clamp = 1'b1;
        end
`ifdef PSUM_REQUANT_RELU_EN
        if (rq_c < 0) begin
            rq_c = '0;
        end
`else
        rq_c = rq_c;
`endif
        act_new = ACT_WIDTH'(rq_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_hs) begin
            state_d = last ? ST_OUTPUT : ST_ACCUM;
        end else if (out_hs) begin
            state_d = ST_ACCUM;
        end
    end

    // In OUTPUT an input is only taken alongside the output handshake.
    always_comb begin
        out_valid = (state_q == ST_OUTPUT);
        in_ready  = (state_q == ST_ACCUM) || bus.out_ready;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_flag_d = sat_flag_q;
        act_d      = act_q;
        osat_d     = osat_q;
        if (in_hs) begin
            acc_d = new_acc;
            if (last) begin
                cnt_d      = '0;
                sat_flag_d = 1'b0;
                act_d      = act_new;
                osat_d     = clamp | sat_flag_q | new_ovf;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                sat_flag_d = sat_flag_q | new_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_flag_q <= 1'b0;
            act_q      <= '0;
            osat_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_flag_d;
            act_q      <= act_d;
            osat_q     <= osat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_act   = act_q;
    assign bus.out_sat   = osat_q;

endmodule

// File: doc/psum_requant_acc.md
# psum_requant_acc

Streaming partial-sum accumulator and requantizer. It consumes signed (12,5) fixed-point partial sums over a valid/ready handshake and accumulates `NUM_TERMS` of them with saturating addition. Each group total is then converted back to the (`ACT_WIDTH`,`ACT_FRAC`) activation format and emitted over a second valid/ready handshake. It sits at the drain end of the PE psum datapath, turning adder-domain psums back into activations for the next layer.

## Interface
- `NUM_TERMS`, 4: psums per output group, ≥1
- `ACT_WIDTH`, 8: output activation width, signed
- `ACT_FRAC`, 4: output fractional bits, 0 ≤ `ACT_FRAC` ≤ 5
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input psum valid
- `in_ready`  out  1  input psum accepted when high with `in_valid`
- `in_psum`  in  `PSUM_DATA_SIZE`  signed (12,5) psum
- `out_valid`  out  1  activation valid
- `out_ready`  in  1  downstream accepts
- `out_act`  out  `ACT_WIDTH`  signed activation (`ACT_WIDTH`,`ACT_FRAC`)
- `out_sat`  out  1  saturation occurred anywhere in this group

## Operation
- State `ACCUM`:
  - `in_ready`=1.
  - On input handshake with `cnt`==0: `acc` <= `in_psum`.
  - Otherwise: `acc` <= sat(`acc`+`in_psum`). The sum is 13-bit. Positive overflow gives 12'h7FF; negative overflow gives 12'h800.
  - `cnt` increments on each handshake. A sticky `sat_flag` ORs in overflow.
- On the handshake where `cnt`==`NUM_TERMS`-1:
  - Requantize the post-add value into the `out_act`/`out_sat` registers.
  - Clear `cnt` and `sat_flag`, then go to `OUTPUT`.
- State `OUTPUT`:
  - `out_valid`=1 and `in_ready`=`out_ready`.
  - Output handshake with no input handshake: go to `ACCUM`.
  - Output handshake and input handshake in the same cycle: the input is the first term of the next group (`acc`<=`in_psum`, `cnt`<=1). If `NUM_TERMS`==1, the new result loads and the block stays in `OUTPUT`.
- Requantize:
  - s = 5−`ACT_FRAC`.
  - If s>0: r = (`acc` + (1<<(s−1))) >>> s, computed in 13 bits with arithmetic shift (round-half-up). If s=0: r = `acc`.
  - Clamp r to [−2^(`ACT_WIDTH`−1), 2^(`ACT_WIDTH`−1)−1]. For width 8 that is 0x80/0x7F.
  - Clamping sets `out_sat`. `out_sat` also carries `sat_flag`, including overflow on the final add.

## Timing
- Reset values: state=`ACCUM`, `acc`=0, `cnt`=0, `sat_flag`=0, `out_valid`=0, `out_act`=0, `out_sat`=0.
- Reset mid-group discards the partial group.
- Latency: `out_valid` rises the cycle after the last-term handshake.
- Throughput: one psum per cycle when `out_ready` is held high, including across group boundaries.
- While `out_valid`=1 and `out_ready`=0: `out_act` and `out_sat` are held stable and `in_ready`=0. No input is lost.
- `in_ready` depends combinationally on `out_ready` in `OUTPUT` only. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- `PSUM_REQUANT_RELU_EN` defined: after requantization, a negative r is forced to 0. The ReLU clamp does not set `out_sat`. Negative-overflow saturation still sets it.
- Undefined: signed output passes through unchanged.

## Test plan
- Group of 4 × 12'h020 (1.0), `ACT_FRAC`=4 → `out_act`=8'h40 (4.0), `out_sat`=0, `out_valid` one cycle after the 4th handshake.
- Terms 12'h7F0, 12'h7F0, 0, 0 → `acc` saturates to 12'h7FF → `out_act`=8'h7F, `out_sat`=1.
- Group of 4 × 12'hFF0 (−0.5) → `acc`=12'hFC0 → `out_act`=8'hE0 (−2.0). With `PSUM_REQUANT_RELU_EN` → 8'h00, `out_sat`=0.
- Rounding: terms 12'h003, 0, 0, 0 → `out_act`=8'h02. Terms 12'h001, 0, 0, 0 → 8'h01.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and `out_act` stable. Release → next group starts in the release cycle, and the back-to-back groups run at 1 psum/cycle.
- Assert `rst` after 2 terms → all outputs 0. A fresh group of 4 × 12'h020 afterwards → 8'h40.
